// File: rtl/viterbi_seq_ctrl_pkg.sv
// Shared definitions for the radix-4 Viterbi decoder control path.
// Holds the sequencer state encoding and the default block geometry, which the
// traceback and extract blocks use as well.
package viterbi_seq_ctrl_pkg;

    // Sequencer phases; the encoding is fixed so other blocks can decode it.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAcs     = 3'd1,
        StTb      = 3'd2,
        StExtract = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam int unsigned TB_DEPTH_DEF   = 30;  // trellis steps per block
    localparam int unsigned OUT_BEATS_DEF  = 15;  // extract beats per block
    localparam int unsigned TB_TIMEOUT_DEF = 255; // cycles allowed for traceback
    localparam int unsigned CNT_W_DEF      = 8;   // step/beat/timeout counter width

endpackage

// File: rtl/viterbi_seq_ctrl_if.sv
// Host, symbol-source and datapath-enable signals of the Viterbi phase sequencer.
//   master : the environment (host, symbol source, traceback unit) - drives i_*
//   slave  : the sequencer - drives o_*
//   i_start/i_abort      frame control from the host
//   i_sym_valid/last     symbol stream, o_sym_ready handshake, o_en_acs step enable
//   o_en_tb/i_tb_done    traceback run level and completion pulse
//   o_en_extract, o_out_valid, o_last_beat   extraction stage control
//   o_step_cnt, o_busy, o_frame_done, o_tb_err  status
interface viterbi_seq_ctrl_if #(
    parameter int unsigned CNT_W = viterbi_seq_ctrl_pkg::CNT_W_DEF
);
    logic             i_start;
    logic             i_abort;
    logic             i_sym_valid;
    logic             i_sym_last;
    logic             o_sym_ready;
    logic             o_en_acs;
    logic             o_en_tb;
    logic             i_tb_done;
    logic             o_en_extract;
    logic             o_out_valid;
    logic             o_last_beat;
    logic [CNT_W-1:0] o_step_cnt;
    logic             o_busy;
    logic             o_frame_done;
    logic             o_tb_err;

    modport master (
        output i_start, i_abort, i_sym_valid, i_sym_last, i_tb_done,
        input  o_sym_ready, o_en_acs, o_en_tb, o_en_extract, o_out_valid, o_last_beat,
               o_step_cnt, o_busy, o_frame_done, o_tb_err
    );

    modport slave (
        input  i_start, i_abort, i_sym_valid, i_sym_last, i_tb_done,
        output o_sym_ready, o_en_acs, o_en_tb, o_en_extract, o_out_valid, o_last_beat,
               o_step_cnt, o_busy, o_frame_done, o_tb_err
    );

endinterface

// File: rtl/viterbi_seq_ctrl_seq_cnt.sv
// Clearable up-counter with a terminal flag, used for the step, beat and
// traceback-timeout counts of the sequencer.
//   clk, rst  clock and asynchronous active-low reset
//   i_clr     synchronous clear to zero (wins over i_inc)
//   i_inc     count up by one
//   o_cnt     current count
//   o_last    count equals TERM-1, i.e. the next increment reaches TERM
module viterbi_seq_ctrl_seq_cnt
    import viterbi_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TERM  = TB_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LastVal = CNT_W'(TERM - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_last = (cnt_q == LastVal);

endmodule

// File: rtl/viterbi_seq_ctrl.sv
// Phase sequencer for the radix-4 Viterbi decoder. Accepts one symbol per
// trellis step, runs ACS for a block of up to TB_DEPTH steps, launches
// traceback, drives extraction for OUT_BEATS beats, and repeats per block
// until the frame's last symbol has been decoded.
//   clk, rst  clock and asynchronous active-low reset
//   bus       viterbi_seq_ctrl_if slave port: frame control, symbol
//             handshake, datapath enables and status (see interface file)
module viterbi_seq_ctrl
    import viterbi_seq_ctrl_pkg::*;
#(
    parameter int unsigned TB_DEPTH   = TB_DEPTH_DEF,
    parameter int unsigned OUT_BEATS  = OUT_BEATS_DEF,
    parameter int unsigned TB_TIMEOUT = TB_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    viterbi_seq_ctrl_if.slave bus
);

    state_e state_q, state_d;
    logic   last_seen_q, last_seen_d;
    logic   tb_err_q, tb_err_d;
    logic   out_valid_q, out_valid_d;
    logic   last_beat_q, last_beat_d;

    logic             sym_ready, accept, en_tb, en_extract;
    logic             step_clr, beat_clr, to_clr;
    logic             step_last, beat_last, to_last;
    logic [CNT_W-1:0] step_cnt, beat_cnt, to_cnt;

    assign sym_ready  = (state_q == StAcs);
    assign accept     = bus.i_sym_valid & sym_ready;
    assign en_tb      = (state_q == StTb);
    assign en_extract = (state_q == StExtract);

    // Beat and timeout counts only live inside their own phase, so holding
    // them cleared elsewhere guarantees a zero start on every entry.
    assign beat_clr = !en_extract | bus.i_abort;
    assign to_clr   = !en_tb | bus.i_abort;

    viterbi_seq_ctrl_seq_cnt #(
        .CNT_W (CNT_W),
        .TERM  (TB_DEPTH)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (step_clr),
        .i_inc  (accept),
        .o_cnt  (step_cnt),
        .o_last (step_last)
    );

    viterbi_seq_ctrl_seq_cnt #(
        .CNT_W (CNT_W),
        .TERM  (OUT_BEATS)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (beat_clr),
        .i_inc  (en_extract),
        .o_cnt  (beat_cnt),
        .o_last (beat_last)
    );

    viterbi_seq_ctrl_seq_cnt #(
        .CNT_W (CNT_W),
        .TERM  (TB_TIMEOUT)
    ) u_to_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (to_clr),
        .i_inc  (en_tb),
        .o_cnt  (to_cnt),
        .o_last (to_last)
    );

    // Only the terminal flags of the beat and timeout counters are needed.
    logic unused_cnts;
    assign unused_cnts = ^{beat_cnt, to_cnt};

    always_comb begin
        state_d     = state_q;
        last_seen_d = last_seen_q;
        tb_err_d    = tb_err_q;
        step_clr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d     = StAcs;
                    last_seen_d = 1'b0;
                    tb_err_d    = 1'b0;
                    step_clr    = 1'b1;
                end
            end
            StAcs: begin
                if (accept) begin
                    if (bus.i_sym_last) begin
                        last_seen_d = 1'b1;
                    end
                    // step_last: this accept brings the count to TB_DEPTH
                    if (step_last || bus.i_sym_last) begin
                        state_d = StTb;
                    end
                end
            end
            StTb: begin
                // A done arriving on the final allowed cycle still wins.
                if (bus.i_tb_done) begin
                    state_d = StExtract;
                end else if (to_last) begin
                    tb_err_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StExtract: begin
                if (beat_last) begin
                    if (last_seen_q) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StAcs;
                        step_clr = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything but keeps the sticky error for the host.
        if (bus.i_abort) begin
            state_d     = StIdle;
            last_seen_d = 1'b0;
            tb_err_d    = tb_err_q;
            step_clr    = 1'b1;
        end
    end

    // Extract output is one pipeline stage behind its enable.
    always_comb begin
        out_valid_d = en_extract & !bus.i_abort;
        last_beat_d = en_extract & beat_last & last_seen_q & !bus.i_abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_seen_q <= 1'b0;
            tb_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            last_beat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_seen_q <= last_seen_d;
            tb_err_q    <= tb_err_d;
            out_valid_q <= out_valid_d;
            last_beat_q <= last_beat_d;
        end
    end

    assign bus.o_sym_ready  = sym_ready;
    assign bus.o_en_acs     = accept;
    assign bus.o_en_tb      = en_tb;
    assign bus.o_en_extract = en_extract;
    assign bus.o_out_valid  = out_valid_q;
    assign bus.o_last_beat  = last_beat_q;
    assign bus.o_step_cnt   = step_cnt;
    assign bus.o_busy       = (state_q != StIdle);
    assign bus.o_frame_done = (state_q == StDone);
    assign bus.o_tb_err     = tb_err_q;

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Scoreboard bench for viterbi_seq_ctrl: a driver issues frames and pushes the
// expected per-block / per-beat / per-frame responses derived from frame length
// arithmetic; a monitor pops and compares whenever the DUT shows an event.
module tb_viterbi_seq_ctrl;

    localparam int DEPTH   = 30;
    localparam int BEATS   = 15;
    localparam int TIMEOUT = 255;

    typedef struct {
        bit err;
        int accepts;
    } frame_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int     exp_block_q[$];  // o_step_cnt at each TB entry
    int     exp_tblen_q[$];  // cycles o_en_tb stays high per TB phase
    int     exp_run_q[$];    // cycles o_en_extract stays high per block
    bit     exp_beat_q[$];   // o_last_beat on each o_out_valid cycle
    frame_t exp_frame_q[$];  // status at each o_frame_done pulse

    viterbi_seq_ctrl_if #(.CNT_W(8)) bus ();

    viterbi_seq_ctrl #(
        .TB_DEPTH   (DEPTH),
        .OUT_BEATS  (BEATS),
        .TB_TIMEOUT (TIMEOUT),
        .CNT_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with nothing expected at %0t", name, $time);
    endtask

    // Reference model: frame of len symbols splits into ceil(len/DEPTH) blocks.
    task automatic push_expect(input int len, input bit give_done, input int delay,
                               input int abort_beat);
        int nblk;
        nblk = (len + DEPTH - 1) / DEPTH;
        for (int b = 0; b < nblk; b++) begin
            int size;
            size = (b == nblk - 1) ? len - DEPTH * (nblk - 1) : DEPTH;
            exp_block_q.push_back(size);
            if (!give_done) begin
                exp_tblen_q.push_back(TIMEOUT);
                exp_frame_q.push_back('{1'b1, DEPTH * b + size});
                return;
            end
            exp_tblen_q.push_back(delay);
            if (abort_beat != 0) begin
                exp_run_q.push_back(abort_beat);
                for (int i = 0; i < abort_beat - 1; i++) exp_beat_q.push_back(1'b0);
                return;
            end
            exp_run_q.push_back(BEATS);
            for (int i = 0; i < BEATS; i++) exp_beat_q.push_back(b == nblk - 1 && i == BEATS - 1);
        end
        exp_frame_q.push_back('{1'b0, len});
    endtask

    task automatic clear_inputs();
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_sym_valid = 1'b0;
        bus.i_sym_last  = 1'b0;
        bus.i_tb_done   = 1'b0;
    endtask

    // stall: 0 valid always, 1 toggling, 2 random. noise: stray i_start and
    // out-of-phase i_tb_done that must be ignored.
    task automatic run_frame(input int len, input int stall, input int delay, input bit give_done,
                             input int abort_beat, input bit noise);
        int sent, tbc, exc, budget;
        bit tog;
        sent = 0; tbc = 0; exc = 0; budget = 0; tog = 1'b1;
        push_expect(len, give_done, delay, abort_beat);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        while (budget < 5000) begin
            clear_inputs();
            if (!bus.o_busy) break;
            if (bus.o_sym_ready && sent < len) begin
                case (stall)
                    0:       bus.i_sym_valid = 1'b1;
                    1:       bus.i_sym_valid = tog;
                    default: bus.i_sym_valid = 1'($urandom % 2);
                endcase
                tog = ~tog;
                if (bus.i_sym_valid) begin
                    bus.i_sym_last = (sent == len - 1);
                    sent++;
                end
            end
            if (bus.o_en_tb) begin
                tbc++;
                if (give_done && tbc == delay) bus.i_tb_done = 1'b1;
            end else begin
                tbc = 0;
                if (noise) bus.i_tb_done = ($urandom % 8 == 0);
            end
            if (bus.o_en_extract) begin
                exc++;
                if (abort_beat != 0 && exc == abort_beat) bus.i_abort = 1'b1;
            end else begin
                exc = 0;
            end
            if (noise && ($urandom % 8 == 0)) bus.i_start = 1'b1;
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 5000) begin
            miss("frame_budget_expired");
            bus.i_abort = 1'b1;
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_sym_ready"}, 32'(bus.o_sym_ready), 0);
        chk({tag, "_en_acs"}, 32'(bus.o_en_acs), 0);
        chk({tag, "_en_tb"}, 32'(bus.o_en_tb), 0);
        chk({tag, "_en_extract"}, 32'(bus.o_en_extract), 0);
        chk({tag, "_out_valid"}, 32'(bus.o_out_valid), 0);
        chk({tag, "_last_beat"}, 32'(bus.o_last_beat), 0);
        chk({tag, "_step_cnt"}, 32'(bus.o_step_cnt), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_frame_done"}, 32'(bus.o_frame_done), 0);
        chk({tag, "_tb_err"}, 32'(bus.o_tb_err), 0);
    endtask

    // Monitor: samples on the falling edge, away from input and state changes.
    initial begin : monitor
        bit     p_tb, p_ext, p_tb_done, p_abort, p_busy, done_seen;
        int     tb_len, ext_len, acs_cnt;
        frame_t f;
        p_tb = 0; p_ext = 0; p_tb_done = 0; p_abort = 0; p_busy = 0; done_seen = 0;
        tb_len = 0; ext_len = 0; acs_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_tb = 0; p_ext = 0; p_tb_done = 0; p_abort = 0; p_busy = 0; done_seen = 0;
                tb_len = 0; ext_len = 0; acs_cnt = 0;
                continue;
            end
            if (bus.o_busy && !p_busy) begin
                acs_cnt = 0;
                chk("tb_err_cleared_by_start", 32'(bus.o_tb_err), 0);
            end
            if (bus.o_en_acs || bus.i_sym_valid)
                chk("en_acs_handshake", 32'(bus.o_en_acs),
                    32'(bus.i_sym_valid && bus.o_sym_ready));
            if (bus.o_en_acs) acs_cnt++;

            if (bus.o_en_tb && !p_tb) begin
                if (exp_block_q.size() == 0) miss("tb_entry");
                else chk("step_cnt_at_tb_entry", 32'(bus.o_step_cnt), exp_block_q.pop_front());
            end
            if (bus.o_en_tb) tb_len++;
            if (!bus.o_en_tb && p_tb) begin
                if (exp_tblen_q.size() == 0) miss("tb_length");
                else chk("tb_length", tb_len, exp_tblen_q.pop_front());
                tb_len = 0;
            end

            if (bus.o_en_extract && !p_ext)
                chk("extract_follows_tb_done", 32'(p_tb_done && p_tb), 1);
            if (bus.o_en_extract) ext_len++;
            if (!bus.o_en_extract && p_ext) begin
                if (exp_run_q.size() == 0) miss("extract_run");
                else chk("extract_run_length", ext_len, exp_run_q.pop_front());
                ext_len = 0;
            end

            if (bus.o_out_valid || (p_ext && !p_abort))
                chk("out_valid_delay", 32'(bus.o_out_valid), 32'(p_ext && !p_abort));
            if (bus.o_out_valid) begin
                if (exp_beat_q.size() == 0) miss("out_beat");
                else chk("last_beat", 32'(bus.o_last_beat), 32'(exp_beat_q.pop_front()));
            end else if (bus.o_last_beat) begin
                miss("last_beat_without_valid");
            end

            if (done_seen) begin
                chk("busy_after_done", 32'(bus.o_busy), 0);
                chk("frame_done_one_cycle", 32'(bus.o_frame_done), 0);
                done_seen = 0;
            end
            if (bus.o_frame_done) begin
                if (exp_frame_q.size() == 0) begin
                    miss("frame_done");
                end else begin
                    f = exp_frame_q.pop_front();
                    chk("frame_tb_err", 32'(bus.o_tb_err), 32'(f.err));
                    chk("frame_accepts", acs_cnt, f.accepts);
                    chk("final_beat_in_done", 32'(bus.o_out_valid), 32'(!f.err));
                    done_seen = 1;
                end
            end

            p_tb      = bus.o_en_tb;
            p_ext     = bus.o_en_extract;
            p_tb_done = bus.i_tb_done;
            p_abort   = bus.i_abort;
            p_busy    = bus.o_busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        rst = 1'b0;
        clear_inputs();
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        run_frame(60, 0, 3, 1'b1, 0, 1'b0);   // two full blocks
        run_frame(7, 0, 4, 1'b1, 0, 1'b0);    // partial block
        run_frame(45, 1, 2, 1'b1, 0, 1'b0);   // source stalls 1/0
        run_frame(10, 0, 1, 1'b0, 0, 1'b0);   // traceback never completes
        chk("tb_err_sticky_in_idle", 32'(bus.o_tb_err), 1);
        run_frame(20, 2, 5, 1'b1, 0, 1'b0);   // start clears the error
        run_frame(35, 0, 3, 1'b1, 5, 1'b0);   // abort on extract beat 5
        chk("abort_idle_busy", 32'(bus.o_busy), 0);
        chk("abort_en_extract", 32'(bus.o_en_extract), 0);
        chk("abort_out_valid", 32'(bus.o_out_valid), 0);
        run_frame(60, 0, 3, 1'b1, 0, 1'b0);   // normal frame after abort

        // Asynchronous reset in the middle of ACS.
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_sym_valid = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_outputs_zero("async_rst");
        clear_inputs();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        run_frame(40, 2, 6, 1'b1, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_frame(int'($urandom_range(1, 100)), int'($urandom_range(0, 2)),
                      int'($urandom_range(1, 10)), 1'b1, 0, 1'b1);
        end
        repeat (3) @(posedge clk);

        chk("leftover_blocks", exp_block_q.size(), 0);
        chk("leftover_tb_lengths", exp_tblen_q.size(), 0);
        chk("leftover_extract_runs", exp_run_q.size(), 0);
        chk("leftover_beats", exp_beat_q.size(), 0);
        chk("leftover_frames", exp_frame_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
